// File: rtl/starfield_layer_ctrl.sv
// starfield_layer_ctrl: sequences NL parallax starfield layers, runs the
// per-frame fade-in/fade-out state machine and composites the layer
// brightnesses by priority into one gained, faded pixel brightness.
module starfield_layer_ctrl #(
   parameter int unsigned NL        = 3,
   parameter int unsigned FADE_STEP = 8,
   parameter int unsigned GAIN_RST  = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_pix_en,
   input  logic              i_frame_start,
   input  logic              i_cmd_start,
   input  logic              i_cmd_stop,
   input  logic              i_cfg_we,
   input  logic [1:0]        i_cfg_addr,
   input  logic [7:0]        i_cfg_data,
   input  logic [NL-1:0]     i_layer_on,
   input  logic [8*NL-1:0]   i_layer_star,
   output logic [NL-1:0]     o_layer_en,
   output logic [NL-1:0]     o_layer_rst,
   output logic              o_star_on,
   output logic [7:0]        o_star_out,
   output logic [1:0]        o_state,
   output logic [7:0]        o_level
);

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_FADE_IN  = 2'd1,
      ST_ON       = 2'd2,
      ST_FADE_OUT = 2'd3
   } state_t;

   localparam logic [8:0] STEP9 = 9'(FADE_STEP);

   state_t      r_state;
   logic [7:0]  r_level;
   logic [7:0]  r_gain [NL];
   logic [7:0]  r_p1;
   logic        r_on1;
   logic        r_star_on;
   logic [7:0]  r_star_out;

   state_t      w_cmd_state;
   logic [8:0]  w_up;
   logic [8:0]  w_dn;
   logic [7:0]  w_up_sat;
   logic [7:0]  w_dn_sat;
   logic [7:0]  w_sel_star;
   logic [7:0]  w_sel_gain;
   logic [15:0] w_p1_prod;
   logic [15:0] w_p2_prod;
   logic        w_s2_on;

   // Direction after this cycle's commands; stop wins, redundant commands are ignored
   always_comb begin
      w_cmd_state = r_state;
      if (i_cmd_stop) begin
         if ((r_state == ST_ON) || (r_state == ST_FADE_IN))
            w_cmd_state = ST_FADE_OUT;
      end else if (i_cmd_start) begin
         if ((r_state == ST_OFF) || (r_state == ST_FADE_OUT))
            w_cmd_state = ST_FADE_IN;
      end
   end

   // Saturating level steps in 9 bits; bit 8 flags overflow or borrow
   assign w_up     = {1'b0, r_level} + STEP9;
   assign w_dn     = {1'b0, r_level} - STEP9;
   assign w_up_sat = w_up[8] ? 8'hFF : w_up[7:0];
   assign w_dn_sat = w_dn[8] ? 8'h00 : w_dn[7:0];

   // Fade FSM: level only moves on frame_start, in the post-command direction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_OFF;
         r_level <= 8'd0;
      end else if (i_frame_start) begin
         case (w_cmd_state)
            ST_FADE_IN: begin
               r_level <= w_up_sat;
               r_state <= (w_up_sat == 8'hFF) ? ST_ON : ST_FADE_IN;
            end
            ST_FADE_OUT: begin
               r_level <= w_dn_sat;
               r_state <= (w_dn_sat == 8'h00) ? ST_OFF : ST_FADE_OUT;
            end
            ST_ON: begin
               r_level <= 8'hFF;
               r_state <= ST_ON;
            end
            default: r_state <= ST_OFF;
         endcase
      end else begin
         r_state <= w_cmd_state;
      end
   end

   // Per-layer gain registers; out-of-range addresses match no layer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NL); k++) r_gain[k] <= 8'(GAIN_RST);
      end else begin
         for (int k = 0; k < int'(NL); k++)
            if (i_cfg_we && (i_cfg_addr == 2'(k))) r_gain[k] <= i_cfg_data;
      end
   end

   // Priority select: lowest-numbered active layer is in front
   always_comb begin
      w_sel_star = 8'd0;
      w_sel_gain = 8'd0;
      for (int k = int'(NL) - 1; k >= 0; k--) begin
         if (i_layer_on[k]) begin
            w_sel_star = i_layer_star[8*k +: 8];
            w_sel_gain = r_gain[k];
         end
      end
   end

   assign w_p1_prod = 16'(w_sel_star) * 16'(w_sel_gain);
   assign w_p2_prod = 16'(r_p1) * 16'(r_level);
   assign w_s2_on   = r_on1 & (r_level != 8'd0);

   // Two-stage composite pipeline: gain stage, then fade stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p1       <= 8'd0;
         r_on1      <= 1'b0;
         r_star_on  <= 1'b0;
         r_star_out <= 8'd0;
      end else begin
         r_p1       <= 8'(w_p1_prod >> 8);
         r_on1      <= |i_layer_on;
         r_star_on  <= w_s2_on;
         r_star_out <= w_s2_on ? 8'(w_p2_prod >> 8) : 8'd0;
      end
   end

   assign o_layer_en  = {NL{i_pix_en & (r_state != ST_OFF)}};
   assign o_layer_rst = {NL{r_state == ST_OFF}};
   assign o_star_on   = r_star_on;
   assign o_star_out  = r_star_out;
   assign o_state     = r_state;
   assign o_level     = r_level;

endmodule
